matrix_multiply_seq: RTL
========================

Name: matrix_multiply_seq

Overview:
- Parametrised, multi-cycle successor to the fixed 4x4 combinational-per-cycle matrix multiplier in the accelerator subsystem (acc/).
- Computes C = A x B for square mat_size x mat_size matrices of dat_size-bit elements, in unsigned or signed (two's complement) mode.
- Uses mat_size parallel MAC lanes, one result row per mat_size cycles, with a start/busy/done handshake for the accelerator control wrapper.

Parameters:
- mat_size, 4, matrix dimension N (N >= 1).
- dat_size, 8, element width of A and B in bits (>= 2).
- acc_size, 2*dat_size+$clog2(mat_size), width of each C element; derived, must not be overridden.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a new multiplication; honoured only in IDLE.
- signed_mode  input  1  0 = unsigned elements, 1 = signed two's complement; sampled with start.
- mat_A  input  [N*N][dat_size]  matrix A, row-major (element [i*N+k] = A[i][k]); sampled with start.
- mat_B  input  [N*N][dat_size]  matrix B, row-major; sampled with start.
- busy  output  1  high while COMPUTE or DONE.
- done  output  1  one-cycle pulse, mat_C complete.
- mat_C  output  [N*N][acc_size]  result, row-major, registered.

Behaviour:
Reset and clock:
- One clock; reset is synchronous and active-high.
- With rst high at a clk edge: state=IDLE, busy=0, done=0, all mat_C elements=0, row/k counters=0, accumulators=0.
- rst has priority over every other input, including mid-COMPUTE. It aborts the operation with no done pulse and clears mat_C.

States:
- IDLE:
  - start=1 at an edge latches mat_A, mat_B and signed_mode into internal registers, clears the accumulators, sets i=0, k=0, and moves to COMPUTE.
  - start=0: stay in IDLE.
- COMPUTE, each cycle:
  - For all j in 0..N-1: acc[j] <= acc[j] + A[i][k]*B[k][j], products extended to acc_size per signed_mode (sign- or zero-extended).
  - If k==N-1: write acc[j]+product into mat_C[i*N+j] for all j, clear acc, set k=0, i=i+1.
  - Otherwise k=k+1.
  - After the step with i==N-1 and k==N-1, move to DONE.
- DONE:
  - done=1 for exactly this cycle, busy=1.
  - Next edge returns to IDLE.
  - start in this cycle is ignored.

Latency and throughput:
- Start accepted at edge T gives COMPUTE during cycles T+1..T+N*N, and done high in cycle T+N*N+1.
- Minimum start-to-start period is N*N+2 cycles.

Handshake and output rules:
- start while busy=1 is ignored; latched operands are not disturbed.
- mat_A, mat_B and signed_mode may change freely after the accepting edge.
- mat_C rows update progressively during COMPUTE; row i is final from the cycle after its last k step.
- The full matrix is guaranteed consistent when done=1, and holds until the next accepted start or reset.

Arithmetic:
- Exact, no overflow possible by choice of acc_size, no saturation or rounding.
- Signed results appear as two's complement in acc_size bits.

Edge cases:
- N=1: COMPUTE lasts 1 cycle, mat_C[0]=A*B, done at T+2.

Test Plan:
1. Defaults, unsigned, A=identity, B[n]=n+1: done exactly 17 cycles after the accepting edge, mat_C[n]=n+1, busy high for 17 cycles.
2. Defaults, unsigned, all A and B elements = 255: every mat_C element = 260100 (0x3F804), no truncation.
3. Defaults, signed_mode=1, all A = -128 (0x80), all B = -128: every mat_C element = 65536. Repeat with all B = 127: every mat_C element = -65024 (0x30200 in 18 bits).
4. Hold start=1 and change mat_A during COMPUTE: result matches the operands from the first accepting edge, and only one done pulse occurs. A start in the DONE cycle gives no new operation.
5. Assert rst for one cycle at COMPUTE cycle 7: no done pulse, mat_C all 0, busy=0 next cycle. A following start gives a correct full result.
6. mat_size=1 and mat_size=3 (dat_size=4), random signed and unsigned operands against a reference model: done at T+2 and T+10 respectively, exact match.

Source files
------------

// File: rtl/matrix_multiply_seq.sv
// Sequential N x N matrix multiplier: one MAC lane per result column,
// one result row every mat_size cycles, start/busy/done handshake.
module matrix_multiply_seq #(
    parameter int mat_size = 4,
    parameter int dat_size = 8,
    parameter int acc_size = 2 * dat_size + $clog2(mat_size)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic                                         signed_mode,
    input  logic [mat_size*mat_size-1:0][dat_size-1:0]   mat_A,
    input  logic [mat_size*mat_size-1:0][dat_size-1:0]   mat_B,
    output logic                                         busy,
    output logic                                         done,
    output logic [mat_size*mat_size-1:0][acc_size-1:0]   mat_C
);

    localparam int num_el = mat_size * mat_size;
    localparam int cnt_w  = (mat_size > 1) ? $clog2(mat_size) : 1;
    // Two spare bits keep the extended operands and their product exact.
    localparam int prod_w = acc_size + 2;

    typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

    state_e                              state_q, state_d;
    logic [num_el-1:0][dat_size-1:0]     a_q, a_d, b_q, b_d;
    logic                                sm_q, sm_d;
    logic [cnt_w-1:0]                    i_q, i_d, k_q, k_d;
    logic [mat_size-1:0][acc_size-1:0]   acc_q, acc_d;
    logic [num_el-1:0][acc_size-1:0]     c_q, c_d;

    logic [dat_size-1:0]                 a_sel;
    logic [mat_size-1:0][dat_size-1:0]   b_sel;
    logic signed [prod_w-1:0]            a_w;
    logic signed [prod_w-1:0]            prod [mat_size];
    logic [mat_size-1:0][acc_size-1:0]   lane_sum;
    logic                                k_last, i_last;

    function automatic logic signed [prod_w-1:0] extend(input logic [dat_size-1:0] v,
                                                        input logic sm);
        logic signed [dat_size:0] v1;
        v1 = $signed({sm & v[dat_size-1], v});
        return prod_w'(v1);
    endfunction

    // A[i][k] is broadcast to every lane; lane j takes B[k][j].
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int n = 0; n < num_el; n++) begin
            if (n == int'(i_q) * mat_size + int'(k_q)) a_sel = a_q[n];
        end
        for (int kk = 0; kk < mat_size; kk++) begin
            for (int j = 0; j < mat_size; j++) begin
                if (kk == int'(k_q)) b_sel[j] = b_q[kk*mat_size+j];
            end
        end
    end

    always_comb begin
        a_w = extend(a_sel, sm_q);
        for (int j = 0; j < mat_size; j++) begin
            prod[j]     = a_w * extend(b_sel[j], sm_q);
            lane_sum[j] = acc_q[j] + prod[j][acc_size-1:0];
        end
    end

    assign k_last = (k_q == cnt_w'(mat_size - 1));
    assign i_last = (i_q == cnt_w'(mat_size - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        i_d     = i_q;
        k_d     = k_q;
        acc_d   = acc_q;
        c_d     = c_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = mat_A;
                    b_d     = mat_B;
                    sm_d    = signed_mode;
                    acc_d   = '0;
                    i_d     = '0;
                    k_d     = '0;
                    state_d = StCompute;
                end
            end
            StCompute: begin
                if (k_last) begin
                    for (int ii = 0; ii < mat_size; ii++) begin
                        for (int jj = 0; jj < mat_size; jj++) begin
                            if (ii == int'(i_q)) c_d[ii*mat_size+jj] = lane_sum[jj];
                        end
                    end
                    acc_d = '0;
                    k_d   = '0;
                    i_d   = i_q + cnt_w'(1);
                    if (i_last) state_d = StDone;
                end else begin
                    acc_d = lane_sum;
                    k_d   = k_q + cnt_w'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            i_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            i_q     <= i_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
        end
    end

    assign busy  = (state_q != StIdle);
    assign done  = (state_q == StDone);
    assign mat_C = c_q;

endmodule
